// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for serial_add_ctrl.
// o_overflow exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
`ifdef SERIAL_ADD_OVF_EN
  logic             o_overflow;

  modport master (
    output i_start, i_a, i_b, i_cin,
    input  o_busy, o_done, o_sum, o_carry, o_overflow
  );

  modport slave (
    input  i_start, i_a, i_b, i_cin,
    output o_busy, o_done, o_sum, o_carry, o_overflow
  );
`else
  modport master (
    output i_start, i_a, i_b, i_cin,
    input  o_busy, o_done, o_sum, o_carry
  );

  modport slave (
    input  i_start, i_a, i_b, i_cin,
    output o_busy, o_done, o_sum, o_carry
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// state | meaning
// IDLE  | waiting for i_start; result registers hold last answer
// RUN   | one bit per cycle through the adder cell, WIDTH cycles
// DONE  | single-cycle o_done pulse, result valid
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a_i (sa_q[0]),
    .b_i (sb_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = RUN;
          sa_d    = bus.i_a;
          sb_d    = bus.i_b;
          c_d     = bus.i_cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {fa_s, res_q[WIDTH-1:1]};
        c_d   = fa_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          // c_q is still the carry into the MSB on this edge
          ovf_d = c_q ^ fa_c;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.o_busy    = (state_q == RUN);
  assign bus.o_done    = (state_q == DONE);
  assign bus.o_sum     = res_q;
  assign bus.o_carry   = c_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.o_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl (WIDTH=8), checked against
// plain-arithmetic expectations; o_overflow checked when SERIAL_ADD_OVF_EN is set.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic i_clk = 1'b0;
  logic i_reset;
  int   passes = 0;
  int   total  = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle; returns in an IDLE cycle after the hold gap.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int gap, input int poke_at);
    logic [W:0] full;
    logic       ovf_exp;
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf_exp = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_cin   = cin;
    tick();
    bus.i_start = 1'b0;
    bus.i_a     = W'($urandom);
    bus.i_b     = W'($urandom);
    bus.i_cin   = 1'($urandom);
    for (int k = 1; k <= W; k++) begin
      check("busy_in_run", {31'b0, bus.o_busy}, 32'd1);
      check("done_in_run", {31'b0, bus.o_done}, 32'd0);
      if (k == poke_at) begin
        bus.i_start = 1'b1;
        bus.i_a     = '1;
        bus.i_b     = '1;
      end else begin
        bus.i_start = 1'b0;
      end
      tick();
    end
    bus.i_start = 1'b0;
    check("done_pulse", {31'b0, bus.o_done}, 32'd1);
    check("busy_in_done", {31'b0, bus.o_busy}, 32'd0);
    check("sum", {24'b0, bus.o_sum}, {24'b0, full[W-1:0]});
    check("carry", {31'b0, bus.o_carry}, {31'b0, full[W]});
`ifdef SERIAL_ADD_OVF_EN
    check("overflow", {31'b0, bus.o_overflow}, {31'b0, ovf_exp});
`endif
    tick();
    check("done_one_cycle", {31'b0, bus.o_done}, 32'd0);
    check("idle_not_busy", {31'b0, bus.o_busy}, 32'd0);
    check("sum_hold", {24'b0, bus.o_sum}, {24'b0, full[W-1:0]});
    check("carry_hold", {31'b0, bus.o_carry}, {31'b0, full[W]});
    for (int g = 0; g < gap; g++) begin
      bus.i_a   = W'($urandom);
      bus.i_b   = W'($urandom);
      bus.i_cin = 1'($urandom);
      tick();
      check("gap_not_busy", {31'b0, bus.o_busy | bus.o_done}, 32'd0);
      check("gap_sum_hold", {24'b0, bus.o_sum}, {24'b0, full[W-1:0]});
      check("gap_carry_hold", {31'b0, bus.o_carry}, {31'b0, full[W]});
    end
  endtask

  initial begin
    logic saw_done;
    i_reset     = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_cin   = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    check("rst_done", {31'b0, bus.o_done}, 32'd0);
    check("rst_sum", {24'b0, bus.o_sum}, 32'd0);
    check("rst_carry", {31'b0, bus.o_carry}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", {31'b0, bus.o_overflow}, 32'd0);
`endif
    i_reset = 1'b0;
    tick();
    check("idle_no_start", {31'b0, bus.o_busy}, 32'd0);

    run_op(8'h3C, 8'h45, 1'b0, 1, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0);
    run_op(8'h00, 8'h00, 1'b1, 2, 0);
    run_op(8'h7F, 8'h00, 1'b1, 0, 0);
    run_op(8'h10, 8'h20, 1'b0, 3, 3);

    // reset in RUN cycle 4 discards the operation
    bus.i_start = 1'b1;
    bus.i_a     = 8'h55;
    bus.i_b     = 8'h66;
    bus.i_cin   = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_busy", {31'b0, bus.o_busy}, 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_rst_busy", {31'b0, bus.o_busy}, 32'd0);
    check("mid_rst_done", {31'b0, bus.o_done}, 32'd0);
    check("mid_rst_sum", {24'b0, bus.o_sum}, 32'd0);
    check("mid_rst_carry", {31'b0, bus.o_carry}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("mid_rst_ovf", {31'b0, bus.o_overflow}, 32'd0);
`endif
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_done || bus.o_busy) saw_done = 1'b1;
      tick();
    end
    check("no_activity_after_reset", {31'b0, saw_done}, 32'd0);
    run_op(8'h01, 8'h02, 1'b0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 5)), 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
